// File: rtl/dds_wave_pkg.sv
// Shared register map, CTRL/STATUS bit positions and loader FSM states
// for the DDS waveform loader.
package dds_wave_pkg;

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_BASE = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_DATA = 2'd3;

    localparam int CTRL_START     = 0;
    localparam int CTRL_ABORT     = 1;
    localparam int CTRL_AUTO_SWAP = 2;
    localparam int CTRL_DONE_CLR  = 3;

    localparam int STAT_BUSY       = 0;
    localparam int STAT_DONE       = 1;
    localparam int STAT_ABORTED    = 2;
    localparam int STAT_FIFO_FULL  = 3;
    localparam int STAT_FIFO_EMPTY = 4;
    localparam int STAT_PLAY_BANK  = 5;

    localparam int CSUM_LSB = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SWAP = 2'd2
    } state_t;

endpackage

// File: rtl/wave_sync_fifo.sv
// Synchronous show-ahead FIFO for waveform samples; flush empties it in one
// cycle and overrides any push or pop issued alongside it.
module wave_sync_fifo #(
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;
    assign pop_data = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/dds_wave_loader.sv
// Avalon-MM loader streaming samples into the inactive DDS RAM bank.
// Optional macro WAVE_CHECKSUM_EN adds a 16-bit sample checksum at LEN[31:16].
module dds_wave_loader
    import dds_wave_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              csi_clk,
    input  logic              csi_reset,
    input  logic              avs_chipselect,
    input  logic [1:0]        avs_address,
    input  logic              avs_write,
    input  logic              avs_read,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest,
    output logic [ADDR_W-1:0] coe_ram_addr,
    output logic [DATA_W-1:0] coe_ram_data,
    output logic              coe_ram_we,
    output logic              coe_ram_bank,
    output logic              coe_play_bank
);

    state_t            state_q, state_n;
    logic [ADDR_W:0]   count_q, len_q;
    logic [ADDR_W-1:0] base_q, ram_addr_q;
    logic [DATA_W-1:0] ram_data_q, fifo_dout;
    logic              auto_swap_q, done_q, aborted_q, play_bank_q, ram_we_q;
    logic              fifo_full, fifo_empty, busy, reg_wr, push;
    logic              start_req, abort_req, done_clr, start_acc, start_load;
    logic              pop, finish_noswap, swap_do, set_done;
    logic [31:0]       status;
    logic              wd_unused;

    assign avs_waitrequest = avs_chipselect && avs_write && (avs_address == REG_DATA) && fifo_full;
    assign reg_wr     = avs_chipselect && avs_write && !avs_waitrequest;
    assign push       = reg_wr && (avs_address == REG_DATA);
    assign start_req  = reg_wr && (avs_address == REG_CTRL) && avs_writedata[CTRL_START];
    assign abort_req  = reg_wr && (avs_address == REG_CTRL) && avs_writedata[CTRL_ABORT];
    assign done_clr   = reg_wr && (avs_address == REG_CTRL) && avs_writedata[CTRL_DONE_CLR];
    assign busy       = (state_q != ST_IDLE);
    assign start_acc  = (state_q == ST_IDLE) && start_req && !abort_req;
    assign start_load = start_acc && (len_q != '0);
    assign set_done   = (start_acc && (len_q == '0)) || finish_noswap || swap_do;
    assign wd_unused  = ^avs_writedata;

    wave_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (csi_clk),
        .rst       (csi_reset),
        .push      (push),
        .push_data (avs_writedata[DATA_W-1:0]),
        .pop       (pop),
        .flush     (abort_req),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_n       = state_q;
        pop           = 1'b0;
        finish_noswap = 1'b0;
        swap_do       = 1'b0;
        case (state_q)
            ST_IDLE: if (start_load) state_n = ST_LOAD;
            ST_LOAD: begin
                if (!abort_req && !fifo_empty) begin
                    pop = 1'b1;
                    if (count_q + 1'b1 == len_q) begin
                        if (auto_swap_q) begin
                            state_n = ST_SWAP;
                        end else begin
                            state_n       = ST_IDLE;
                            finish_noswap = 1'b1;
                        end
                    end
                end
            end
            ST_SWAP: begin
                state_n = ST_IDLE;
                swap_do = !abort_req;
            end
            default: state_n = ST_IDLE;
        endcase
        if (abort_req) state_n = ST_IDLE;
    end

    always_ff @(posedge csi_clk or posedge csi_reset) begin
        if (csi_reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            base_q      <= '0;
            len_q       <= '0;
            auto_swap_q <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            play_bank_q <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
        end else begin
            state_q  <= state_n;
            ram_we_q <= pop;
            // Sample address is taken before the increment, so it is BASE+count.
            if (pop) begin
                ram_addr_q <= base_q + count_q[ADDR_W-1:0];
                ram_data_q <= fifo_dout;
                count_q    <= count_q + 1'b1;
            end
            if (start_load) count_q <= '0;
            if (start_acc) auto_swap_q <= avs_writedata[CTRL_AUTO_SWAP];
            if (reg_wr && (avs_address == REG_BASE) && !busy) base_q <= avs_writedata[ADDR_W-1:0];
            if (reg_wr && (avs_address == REG_LEN) && !busy) len_q <= avs_writedata[ADDR_W:0];
            if (done_clr || start_load) begin
                done_q    <= 1'b0;
                aborted_q <= 1'b0;
            end
            if (set_done) done_q <= 1'b1;
            if (abort_req) aborted_q <= 1'b1;
            if (swap_do) play_bank_q <= ~play_bank_q;
        end
    end

`ifdef WAVE_CHECKSUM_EN
    logic [15:0] csum_q;

    always_ff @(posedge csi_clk or posedge csi_reset) begin
        if (csi_reset) begin
            csum_q <= '0;
        end else if (start_acc) begin
            csum_q <= '0;
        end else if (ram_we_q) begin
            csum_q <= csum_q + 16'(ram_data_q);
        end
    end
`endif

    always_comb begin
        status                  = '0;
        status[STAT_BUSY]       = busy;
        status[STAT_DONE]       = done_q;
        status[STAT_ABORTED]    = aborted_q;
        status[STAT_FIFO_FULL]  = fifo_full;
        status[STAT_FIFO_EMPTY] = fifo_empty;
        status[STAT_PLAY_BANK]  = play_bank_q;
    end

    always_comb begin
        avs_readdata = '0;
        if (avs_chipselect && avs_read) begin
            case (avs_address)
                REG_CTRL: avs_readdata = status;
                REG_BASE: avs_readdata[ADDR_W-1:0] = base_q;
                REG_LEN: begin
                    avs_readdata[ADDR_W:0] = len_q;
`ifdef WAVE_CHECKSUM_EN
                    avs_readdata[CSUM_LSB +: 16] = csum_q;
`endif
                end
                default: avs_readdata = '0;
            endcase
        end
    end

    assign coe_ram_addr  = ram_addr_q;
    assign coe_ram_data  = ram_data_q;
    assign coe_ram_we    = ram_we_q;
    assign coe_play_bank = play_bank_q;
    assign coe_ram_bank  = ~play_bank_q;

endmodule
